// File: rtl/ram_dp_hs.sv
// rtl/ram_dp_hs.sv - parametrised simple dual-port RAM with handshakes, lane mask and post-reset clear sweep
//
// Ports:
//   clock       sole clock, rising edge
//   reset       synchronous active-high reset
//   write       write request (accepted when WriteReady is high)
//   WriteAddr   write word address
//   WriteData   write data
//   WriteMask   per-lane write enables, bit i covers WriteData[i*LANE_W +: LANE_W]
//   WriteReady  high when a write can be accepted (RUN state)
//   read        read request (accepted every RUN cycle, no back-pressure)
//   ReadAddr    read word address
//   ReadData    read data, valid while ReadReady is high, held otherwise
//   ReadReady   one-cycle strobe per accepted read, READ_LAT cycles after accept
//   InitDone    high once the block is operational
module ram_dp_hs #(
  parameter int                DATA_W     = 8,
  parameter int                LANE_W     = 8,
  parameter int                ADDR_W     = 4,
  parameter int                READ_LAT   = 1,
  parameter int                INIT_CLEAR = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          WriteAddr,
  input  logic [DATA_W-1:0]          WriteData,
  input  logic [DATA_W/LANE_W-1:0]   WriteMask,
  output logic                       WriteReady,
  input  logic                       read,
  input  logic [ADDR_W-1:0]          ReadAddr,
  output logic [DATA_W-1:0]          ReadData,
  output logic                       ReadReady,
  output logic                       InitDone
);

  localparam int NLANE = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   sweep_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_acc;
  logic                rd_acc;
  logic                sweep_we;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd_word;

  logic                pipe_v [READ_LAT];
  logic [DATA_W-1:0]   pipe_d [READ_LAT];

  // Requests are only honoured in RUN; a request coinciding with reset is dropped.
  assign wr_acc   = (state == RUN) && write && !reset;
  assign rd_acc   = (state == RUN) && read && !reset;
  assign sweep_we = (state == INIT) && (INIT_CLEAR != 0) && !reset;

  // Merge masked lanes of the new data over the currently stored word.
  always_comb begin
    wr_merged = mem[WriteAddr];
    for (int l = 0; l < NLANE; l++) begin
      if (WriteMask[l]) begin
        wr_merged[l*LANE_W +: LANE_W] = WriteData[l*LANE_W +: LANE_W];
      end
    end
  end

  // Write-first: a same-edge write to the read address is forwarded into the read.
  assign rd_word = (wr_acc && (WriteAddr == ReadAddr)) ? wr_merged : mem[ReadAddr];

  // Storage has no reset so contents survive a reset when no sweep is configured.
  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem[sweep_cnt] <= INIT_VALUE;
    end else if (wr_acc) begin
      mem[WriteAddr] <= wr_merged;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      WriteReady <= 1'b0;
      InitDone   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          // The sweep writes the last address on the same edge that enters RUN.
          if ((INIT_CLEAR == 0) || (sweep_cnt == ADDR_W'(DEPTH - 1))) begin
            state      <= RUN;
            WriteReady <= 1'b1;
            InitDone   <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        RUN: begin
          state      <= RUN;
          WriteReady <= 1'b1;
          InitDone   <= 1'b1;
        end
        default: begin
          state      <= INIT;
          WriteReady <= 1'b0;
          InitDone   <= 1'b0;
        end
      endcase
    end
  end

  // Read pipeline: data is captured at accept; each stage only moves data along
  // with a valid token so the final stage holds the last returned word.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < READ_LAT; k++) begin
        pipe_v[k] <= 1'b0;
        pipe_d[k] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_acc;
      if (rd_acc) begin
        pipe_d[0] <= rd_word;
      end
      for (int k = 1; k < READ_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        if (pipe_v[k-1]) begin
          pipe_d[k] <= pipe_d[k-1];
        end
      end
    end
  end

  assign ReadReady = pipe_v[READ_LAT-1];
  assign ReadData  = pipe_d[READ_LAT-1];

endmodule

// File: tb/tb_ram_dp_hs.sv
// tb/tb_ram_dp_hs.sv - self-checking bench for ram_dp_hs (8-bit/lat 1 and 16-bit/lat 3 instances)
module tb_ram_dp_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: DATA_W=16, two lanes, READ_LAT=3, INIT_VALUE=5A5A.
  logic        in_rst   [2];
  logic        in_write [2];
  logic        in_read  [2];
  logic [3:0]  in_waddr [2];
  logic [3:0]  in_raddr [2];
  logic [15:0] in_wdata [2];
  logic [1:0]  in_wmask [2];

  logic [7:0]  a_rd;
  logic        a_rr, a_wrdy, a_done;
  logic [15:0] b_rd;
  logic        b_rr, b_wrdy, b_done;

  ram_dp_hs u_a (
    .clock      (clk),
    .reset      (in_rst[0]),
    .write      (in_write[0]),
    .WriteAddr  (in_waddr[0]),
    .WriteData  (in_wdata[0][7:0]),
    .WriteMask  (in_wmask[0][0:0]),
    .WriteReady (a_wrdy),
    .read       (in_read[0]),
    .ReadAddr   (in_raddr[0]),
    .ReadData   (a_rd),
    .ReadReady  (a_rr),
    .InitDone   (a_done)
  );

  ram_dp_hs #(
    .DATA_W     (16),
    .LANE_W     (8),
    .ADDR_W     (4),
    .READ_LAT   (3),
    .INIT_CLEAR (1),
    .INIT_VALUE (16'h5A5A)
  ) u_b (
    .clock      (clk),
    .reset      (in_rst[1]),
    .write      (in_write[1]),
    .WriteAddr  (in_waddr[1]),
    .WriteData  (in_wdata[1]),
    .WriteMask  (in_wmask[1]),
    .WriteReady (b_wrdy),
    .read       (in_read[1]),
    .ReadAddr   (in_raddr[1]),
    .ReadData   (b_rd),
    .ReadReady  (b_rr),
    .InitDone   (b_done)
  );

  // Reference model: word arrays, remaining INIT cycles, and a queue of
  // expected read returns tagged with the cycle they must appear in.
  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  logic [15:0] mmem [2][16];
  int          left [2];
  bit          started [2];
  logic [15:0] last [2];
  rd_t         qa[$];
  rd_t         qb[$];
  int          cyc;
  int          checks;
  int          fails;

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] initv(int i);
    return (i == 0) ? 16'h0000 : 16'h5A5A;
  endfunction

  function automatic logic [15:0] dmask(int i);
    return (i == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input int i);
    rd_t r;
    if (in_rst[i]) begin
      started[i] = 1'b1;
      left[i]    = 16;
      last[i]    = 16'h0000;
      for (int k = 0; k < 16; k++) mmem[i][k] = initv(i);
      if (i == 0) qa.delete(); else qb.delete();
    end else if (left[i] > 0) begin
      left[i]--;
    end else begin
      if (in_write[i]) begin
        for (int l = 0; l < ((i == 0) ? 1 : 2); l++) begin
          if (in_wmask[i][l]) mmem[i][in_waddr[i]][8*l +: 8] = in_wdata[i][8*l +: 8];
        end
      end
      if (in_read[i]) begin
        r.due  = cyc + lat(i);
        r.data = mmem[i][in_raddr[i]] & dmask(i);
        if (i == 0) qa.push_back(r); else qb.push_back(r);
      end
    end
  endtask

  task automatic check_outputs(input int i);
    logic        rr, done, wrdy;
    logic [15:0] rd;
    bit          exp_rr;
    rd_t         r;
    if (!started[i]) return;
    rr   = (i == 0) ? a_rr   : b_rr;
    done = (i == 0) ? a_done : b_done;
    wrdy = (i == 0) ? a_wrdy : b_wrdy;
    rd   = (i == 0) ? {8'h00, a_rd} : b_rd;
    exp_rr = 1'b0;
    if (i == 0 && qa.size() > 0 && qa[0].due == cyc) begin
      exp_rr = 1'b1;
      r = qa.pop_front();
    end
    if (i == 1 && qb.size() > 0 && qb[0].due == cyc) begin
      exp_rr = 1'b1;
      r = qb.pop_front();
    end
    if (exp_rr) last[i] = r.data;
    chk($sformatf("model inst%0d ReadReady", i), {15'b0, rr}, {15'b0, exp_rr});
    chk($sformatf("model inst%0d ReadData", i), rd, last[i]);
    chk($sformatf("model inst%0d InitDone", i), {15'b0, done}, {15'b0, left[i] == 0});
    chk($sformatf("model inst%0d WriteReady", i), {15'b0, wrdy}, {15'b0, left[i] == 0});
  endtask

  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic idle(input int i);
    in_rst[i]   = 1'b0;
    in_write[i] = 1'b0;
    in_read[i]  = 1'b0;
    in_wmask[i] = 2'b00;
  endtask

  task automatic do_write(input int i, input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    in_write[i] = 1'b1;
    in_waddr[i] = a;
    in_wdata[i] = d;
    in_wmask[i] = m;
  endtask

  task automatic do_read(input int i, input logic [3:0] a);
    in_read[i]  = 1'b1;
    in_raddr[i] = a;
  endtask

  typedef struct {
    logic       w;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       wm;
    logic       r;
    logic [3:0] ra;
    logic       exp_rr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [8];
  int   n;
  bit   seen_rr;

  initial begin
    tbl[0] = '{1'b1, 4'd3,  8'hA5, 1'b1, 1'b0, 4'd0,  1'b0, 8'h00};
    tbl[1] = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 4'd3,  1'b1, 8'hA5};
    tbl[2] = '{1'b1, 4'd9,  8'h77, 1'b1, 1'b1, 4'd9,  1'b1, 8'h77};
    tbl[3] = '{1'b1, 4'd10, 8'h11, 1'b1, 1'b0, 4'd0,  1'b0, 8'h77};
    tbl[4] = '{1'b1, 4'd9,  8'h88, 1'b1, 1'b1, 4'd10, 1'b1, 8'h11};
    tbl[5] = '{1'b1, 4'd4,  8'hFF, 1'b0, 1'b1, 4'd4,  1'b1, 8'h00};
    tbl[6] = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  1'b0, 8'h00};
    tbl[7] = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 4'd9,  1'b1, 8'h88};

    cyc = 0; checks = 0; fails = 0;
    for (int i = 0; i < 2; i++) begin
      idle(i);
      in_waddr[i] = '0; in_raddr[i] = '0; in_wdata[i] = '0;
      started[i] = 1'b0; left[i] = 16; last[i] = '0;
      in_rst[i] = 1'b1;
    end
    tick();
    idle(0); idle(1);

    // Sweep length after reset deasserts.
    n = 0;
    while (!a_done && n < 100) begin
      tick();
      n++;
    end
    chk("init cycles", 16'(n), 16'd16);

    // Every word of the default instance reads back the clear value.
    for (int a = 0; a < 16; a++) begin
      do_read(0, 4'(a));
      tick();
      idle(0);
      chk($sformatf("cleared addr %0d ReadReady", a), {15'b0, a_rr}, 16'd1);
      chk($sformatf("cleared addr %0d ReadData", a), {8'h00, a_rd}, 16'h0000);
    end

    // Directed vectors on the READ_LAT=1 instance, checked after the edge.
    for (int v = 0; v < 8; v++) begin
      in_write[0] = tbl[v].w;
      in_waddr[0] = tbl[v].wa;
      in_wdata[0] = {8'h00, tbl[v].wd};
      in_wmask[0] = {1'b0, tbl[v].wm};
      in_read[0]  = tbl[v].r;
      in_raddr[0] = tbl[v].ra;
      tick();
      chk($sformatf("vec %0d ReadReady", v), {15'b0, a_rr}, {15'b0, tbl[v].exp_rr});
      chk($sformatf("vec %0d ReadData", v), {8'h00, a_rd}, {8'h00, tbl[v].exp_rd});
    end
    idle(0);

    // Lane mask on the 16-bit instance.
    do_write(1, 4'd5, 16'h1234, 2'b11); tick();
    do_write(1, 4'd5, 16'hABCD, 2'b10); tick();
    idle(1); do_read(1, 4'd5); tick();
    idle(1); tick(); tick();
    chk("mask merge ReadReady", {15'b0, b_rr}, 16'd1);
    chk("mask merge ReadData", b_rd, 16'hAB34);

    // READ_LAT=3 back-to-back reads.
    for (int k = 0; k < 4; k++) begin
      do_write(1, 4'(k), 16'h1000 + 16'(k), 2'b11);
      tick();
    end
    idle(1);
    for (int k = 0; k < 7; k++) begin
      in_read[1]  = (k < 4);
      in_raddr[1] = 4'(k);
      tick();
      chk($sformatf("lat3 slot %0d ReadReady", k), {15'b0, b_rr}, {15'b0, (k >= 2 && k <= 5)});
      if (k >= 2 && k <= 5) chk($sformatf("lat3 slot %0d ReadData", k), b_rd, 16'h1000 + 16'(k - 2));
    end
    idle(1);

    // Reset one cycle after a read: the read is dropped and the sweep reruns.
    do_read(1, 4'd3); tick();
    idle(1); in_rst[1] = 1'b1; do_write(1, 4'd7, 16'hFFFF, 2'b11); tick();
    idle(1);
    seen_rr = b_rr;
    n = 0;
    while (!b_done && n < 100) begin
      tick();
      if (b_rr) seen_rr = 1'b1;
      n++;
    end
    chk("reset drop ReadReady", {15'b0, seen_rr}, 16'd0);
    chk("re-sweep cycles", 16'(n), 16'd16);
    do_read(1, 4'd3); tick();
    idle(1); tick(); tick();
    chk("re-sweep addr 3", b_rd, 16'h5A5A);

    // Randomised traffic on both instances, including occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_rst[i]   = ($urandom_range(0, 79) == 0);
        in_write[i] = $urandom_range(0, 1) == 1;
        in_waddr[i] = 4'($urandom_range(0, 15));
        in_wdata[i] = 16'($urandom);
        in_wmask[i] = 2'($urandom_range(0, 3));
        in_read[i]  = $urandom_range(0, 1) == 1;
        in_raddr[i] = (($urandom_range(0, 3) == 0)) ? in_waddr[i] : 4'($urandom_range(0, 15));
      end
      tick();
    end
    idle(0); idle(1);
    for (int c = 0; c < 20; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
